// File: rtl/data_mem_ctrl.sv
// Purpose: single-port word data memory behind a valid/ready request port with a fixed-latency response pulse.
// Latency: response during the cycle Latency+1 after the acceptance cycle; writes commit at the acceptance edge.
// Backpressure: mem_ready_o is high only while Idle; one request in flight, inputs outside Idle are ignored.
//
// Ports:
//   clk_i, rst_ni                  clock (rising edge), asynchronous active-low reset
//   mem_valid_i / mem_ready_o      request handshake
//   mem_addr_i, mem_wdata_i        byte address (bits [1:0] ignored), lane-aligned write data
//   mem_wmask_i                    byte write enables, all-zero means read
//   mem_rdata_o, mem_rvalid_o      post-access word, one-cycle response pulse
//   mem_err_o                      response was for an out-of-range address

package core_pkg;
    localparam int Xlen = 32;
endpackage

module data_mem_ctrl #(
    parameter int              Xlen     = core_pkg::Xlen,
    parameter int              Depth    = 1024,
    parameter int              Latency  = 1,
    parameter logic [Xlen-1:0] BaseAddr = Xlen'(32'h0000_0000)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              mem_valid_i,
    output logic              mem_ready_o,
    input  logic [Xlen-1:0]   mem_addr_i,
    input  logic [Xlen-1:0]   mem_wdata_i,
    input  logic [Xlen/8-1:0] mem_wmask_i,
    output logic [Xlen-1:0]   mem_rdata_o,
    output logic              mem_rvalid_o,
    output logic              mem_err_o
);

    localparam int              IdxW       = $clog2(Depth);
    localparam int              NumBytes   = Xlen / 8;
    // One extra bit so Depth*4 cannot wrap to zero for a full address space.
    localparam logic [Xlen:0]   RangeBytes = (Xlen + 1)'(Depth) << 2;
    localparam logic [3:0]      CntLoad    = (Latency > 0) ? 4'(Latency - 1) : 4'd0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_cnt;
    logic [IdxW-1:0] r_idx;
    logic            r_in_range;
    logic [Xlen-1:0] r_mem [Depth];

    logic [Xlen-1:0] w_offset;
    logic            w_in_range;
    logic [IdxW-1:0] w_idx;
    logic            w_accept;
    logic            w_resp;

    // Unsigned wrap of the subtraction makes addresses below BaseAddr land far out of range.
    assign w_offset   = mem_addr_i - BaseAddr;
    assign w_in_range = {1'b0, w_offset} < RangeBytes;
    assign w_idx      = w_offset[IdxW+1:2];
    // rst_ni gates the array write so a clock edge during reset never commits a request.
    assign w_accept   = (r_state == S_IDLE) && mem_valid_i && rst_ni;
    assign w_resp     = (r_state == S_RESP);

    // State register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (mem_valid_i) begin
                    w_state_nxt = (Latency > 0) ? S_WAIT : S_RESP;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = S_RESP;
                end
            end
            S_RESP:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Wait counter and captured request; only the index and range flag are needed
    // because the write itself completes at acceptance.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_cnt      <= 4'd0;
            r_idx      <= '0;
            r_in_range <= 1'b0;
        end else if (r_state == S_IDLE && mem_valid_i) begin
            r_cnt      <= CntLoad;
            r_idx      <= w_idx;
            r_in_range <= w_in_range;
        end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Storage array, intentionally not reset.
    always_ff @(posedge clk_i) begin
        if (w_accept && w_in_range) begin
            for (int b = 0; b < NumBytes; b++) begin
                if (mem_wmask_i[b]) begin
                    r_mem[w_idx][b*8 +: 8] <= mem_wdata_i[b*8 +: 8];
                end
            end
        end
    end

    // Outputs; rdata is read in the Respond cycle so it reflects this request's write.
    always_comb begin
        mem_ready_o  = (r_state == S_IDLE);
        mem_rvalid_o = w_resp;
        mem_err_o    = 1'b0;
        mem_rdata_o  = '0;
        if (w_resp) begin
            mem_err_o = !r_in_range;
            if (r_in_range) begin
                mem_rdata_o = r_mem[r_idx];
            end
        end
    end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter Xlen, default core_pkg::Xlen (32), data/address width.
REQ-002 SHALL have parameter Depth, default 1024, number of Xlen-bit words in the array (power of two).
REQ-003 SHALL have parameter Latency, default 1, extra wait cycles between acceptance and response (0..15).
REQ-004 SHALL have parameter BaseAddr, default 32'h0000_0000, byte address of word 0.
REQ-005 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-006 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port mem_valid_i  input  1  request present.
REQ-008 SHALL have port mem_ready_o  output  1  controller can accept a request.
REQ-009 SHALL have port mem_addr_i  input  Xlen  byte address; bits [1:0] ignored.
REQ-010 SHALL have port mem_wdata_i  input  Xlen  write data, already lane-aligned.
REQ-011 SHALL have port mem_wmask_i  input  Xlen/8  byte write enables; all-zero means read.
REQ-012 SHALL have port mem_rdata_o  output  Xlen  full word read data.
REQ-013 SHALL have port mem_rvalid_o  output  1  one-cycle response pulse, for reads and writes.
REQ-014 SHALL have port mem_err_o  output  1  response is for an out-of-range address; valid only with mem_rvalid_o.

Function
REQ-015 SHALL implement states Idle, Wait, Respond; mem_ready_o = 1 only in Idle.
REQ-016 SHALL accept a request on a rising edge where state is Idle and mem_valid_i = 1; at that edge capture address, wmask, wdata.
REQ-017 SHALL transition Idle->Wait on acceptance when Latency > 0 (load counter with Latency-1), else Idle->Respond.
REQ-018 SHALL decrement the counter each Wait cycle and go Wait->Respond on the edge when counter = 0.
REQ-019 SHALL go Respond->Idle unconditionally after one cycle; one outstanding request maximum.
REQ-020 SHALL assert mem_rvalid_o exactly during the Respond cycle, i.e. cycle N+1+Latency for acceptance edge N.
REQ-021 SHALL compute in-range as (addr - BaseAddr) < Depth*4 (unsigned, Xlen-bit wrap); word index = (addr - BaseAddr) >> 2.
REQ-022 SHALL commit an in-range write at the acceptance edge, updating only bytes whose wmask bit is 1.
REQ-023 SHALL return in mem_rdata_o the full word at the captured index as it stands after any write by the same request; a write response returns the post-write word.
REQ-024 SHALL, for out-of-range requests, perform no array write, drive mem_rdata_o = 0 and mem_err_o = 1 in the Respond cycle.
REQ-025 SHALL drive mem_rdata_o = 0 and mem_err_o = 0 whenever mem_rvalid_o = 0.
REQ-026 SHALL ignore mem_valid_i and all request inputs outside Idle; input changes after acceptance do not affect the response.
REQ-027 SHALL leave array contents uninitialised; no reset of the array.

Reset
REQ-028 SHALL, while rst_ni = 0, force state Idle, counter 0, mem_ready_o = 1, mem_rvalid_o = 0, mem_rdata_o = 0, mem_err_o = 0, independent of clk_i.
REQ-029 SHALL, on reset mid-transaction, drop the pending response; a write already committed at acceptance remains in the array.
REQ-030 SHALL accept a new request on the first rising edge after rst_ni rises if mem_valid_i = 1.

Verification
REQ-031 SHALL cover: Latency=1, write addr 0x10 wdata 0xDEADBEEF wmask 4'b1111, then read 0x10 -> write rvalid 2 cycles after acceptance with rdata 0xDEADBEEF; read rdata 0xDEADBEEF, err 0.
REQ-032 SHALL cover: word 0x20 = 0x11223344, write wdata 0x0000AA00 wmask 4'b0010 -> subsequent read returns 0x1122AA44.
REQ-033 SHALL cover: Latency=0 and Latency=3 -> rvalid exactly 1 and 4 cycles after acceptance; mem_ready_o low from acceptance through Respond.
REQ-034 SHALL cover: Depth=1024, write to 0x1000 -> rvalid with err 1, rdata 0; read of 0x0 unchanged.
REQ-035 SHALL cover: assert rst_ni = 0 during Wait of a write to 0x40 -> rvalid never pulses, ready_o = 1 immediately; later read 0x40 returns written value.
REQ-036 SHALL cover: mem_valid_i held high continuously with changing addresses -> one acceptance per Idle visit, responses match addresses sampled at each acceptance.
